// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the round-robin / fixed-priority arbiter
//
// Purpose : arbitration mode and FSM state enums plus the index-width helper
//           used by rr_pick and rr_priority_arbiter.
// Ports   : none (package).

package arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // A single requester still needs a 1-bit index port.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational first-set search, fixed-priority or rotated
//
// Purpose : picks one set bit of i_vec.
//             fixed mode : highest set index wins, i_start_idx ignored.
//             rr mode    : first set bit at or after i_start_idx, ascending,
//                          wrapping modulo NUM_REQ.
// Ports   : i_vec        [NUM_REQ-1:0] candidate vector
//           i_start_idx  [IDX_W-1:0]   first index examined in rr mode (< NUM_REQ)
//           i_fixed_mode               1 = fixed priority, 0 = rotated search
//           o_found                    some bit of i_vec is set
//           o_idx        [IDX_W-1:0]   winning index (0 when nothing found)
//           o_onehot     [NUM_REQ-1:0] one-hot of o_idx, zero when nothing found

module rr_pick
  import arb_pkg::*;
#(
  parameter  int NUM_REQ = 8,
  localparam int IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_vec,
  input  logic [IDX_W-1:0]   i_start_idx,
  input  logic               i_fixed_mode,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx,
  output logic [NUM_REQ-1:0] o_onehot
);

  logic [NUM_REQ-1:0] w_rot;
  int                 w_sum;

  // Rotate right by the start index so bit j of w_rot is requester
  // (start + j) mod NUM_REQ; the lowest set bit of w_rot is then the winner.
  assign w_rot = NUM_REQ'({i_vec, i_vec} >> i_start_idx);

  always_comb begin
    o_found  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    w_sum    = 0;
    if (i_fixed_mode) begin
      // Ascending scan, so the last hit written is the highest index.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i_vec[i]) begin
          o_found = 1'b1;
          o_idx   = IDX_W'(i);
        end
      end
    end else begin
      // Descending scan, so the last hit written is the lowest rotated offset.
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
        if (w_rot[j]) begin
          o_found = 1'b1;
          w_sum   = int'(i_start_idx) + j;
        end
      end
      // start < NUM_REQ and offset < NUM_REQ, so one subtraction suffices
      // and no out-of-range index can appear for non-power-of-2 sizes.
      if (w_sum >= NUM_REQ) begin
        w_sum = w_sum - NUM_REQ;
      end
      o_idx = IDX_W'(w_sum);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      o_onehot[i] = o_found && (o_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// rtl/rr_priority_arbiter.sv - registered N-way arbiter with valid/ready grant handshake
//
// Purpose : arbitrates a level request vector onto one shared resource.
//           MODE selects fixed priority (highest index) or round robin.
//           A presented grant is frozen until the consumer accepts it; on
//           acceptance the just-granted requester is masked out so a new
//           grant can follow in the same cycle.
// Ports   : clk                      rising-edge clock
//           rst_n                    asynchronous active-low reset
//           req        [NUM_REQ-1:0] request vector, bit i = requester i
//           gnt_valid                grant presented
//           gnt_ready                consumer accepts the grant
//           gnt_idx    [IDX_W-1:0]   granted requester index
//           gnt_onehot [NUM_REQ-1:0] one-hot of gnt_idx, zero when no grant

module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter  int        NUM_REQ = 8,
  parameter  arb_mode_e MODE    = ARB_RR,
  localparam int        IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic               gnt_valid,
  input  logic               gnt_ready,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic [NUM_REQ-1:0] gnt_onehot
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [NUM_REQ-1:0] r_onehot;
  logic [NUM_REQ-1:0] w_onehot_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptr_nxt;

  logic               w_handshake;
  logic [IDX_W-1:0]   w_base_ptr;
  logic [IDX_W-1:0]   w_start;
  logic [NUM_REQ-1:0] w_pick_vec;
  logic               w_found;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [NUM_REQ-1:0] w_pick_onehot;

  assign w_handshake = (r_state == GRANT) && gnt_ready;

  // On a handshake the pointer moves to the index just granted, and the
  // follow-on pick in that same cycle must already use the moved pointer.
  assign w_base_ptr = (w_handshake && (MODE == ARB_RR)) ? r_idx : r_ptr;
  assign w_start    = (w_base_ptr == LAST_IDX) ? '0 : (w_base_ptr + 1'b1);

  // In GRANT the current winner is excluded so it cannot win twice in a row.
  assign w_pick_vec = (r_state == GRANT) ? (req & ~r_onehot) : req;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_vec        (w_pick_vec),
    .i_start_idx  (w_start),
    .i_fixed_mode (MODE == ARB_FIXED),
    .o_found      (w_found),
    .o_idx        (w_pick_idx),
    .o_onehot     (w_pick_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_ptr    <= LAST_IDX;
    end else begin
      r_state  <= w_state_nxt;
      r_valid  <= w_valid_nxt;
      r_idx    <= w_idx_nxt;
      r_onehot <= w_onehot_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = r_valid;
    w_idx_nxt    = r_idx;
    w_onehot_nxt = r_onehot;
    w_ptr_nxt    = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt  = GRANT;
          w_valid_nxt  = 1'b1;
          w_idx_nxt    = w_pick_idx;
          w_onehot_nxt = w_pick_onehot;
        end
      end
      GRANT: begin
        // Without ready the grant is frozen; req changes are ignored.
        if (gnt_ready) begin
          w_ptr_nxt = w_base_ptr;
          if (w_found) begin
            w_idx_nxt    = w_pick_idx;
            w_onehot_nxt = w_pick_onehot;
          end else begin
            w_state_nxt  = IDLE;
            w_valid_nxt  = 1'b0;
            w_onehot_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_valid_nxt  = 1'b0;
        w_onehot_nxt = '0;
      end
    endcase
  end

  assign gnt_valid  = r_valid;
  assign gnt_idx    = r_idx;
  assign gnt_onehot = r_onehot;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb/tb_rr_priority_arbiter.sv - directed and model-checked bench for rr_priority_arbiter

module tb_rr_priority_arbiter;
  import arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] req_f, req_r, oh_f, oh_r;
  logic       rdy_f, rdy_r, vld_f, vld_r;
  logic [2:0] idx_f, idx_r;
  logic [4:0] req_5, oh_5;
  logic       rdy_5, vld_5;
  logic [2:0] idx_5;
  logic       req_1, rdy_1, vld_1, idx_1, oh_1;

  int checks   = 0;
  int failures = 0;

  logic m_valid [2];
  int   m_idx   [2];
  int   m_ptr   [2];

  rr_priority_arbiter #(.NUM_REQ(8), .MODE(ARB_FIXED)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(req_f), .gnt_valid(vld_f),
    .gnt_ready(rdy_f), .gnt_idx(idx_f), .gnt_onehot(oh_f));

  rr_priority_arbiter #(.NUM_REQ(8), .MODE(ARB_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req_r), .gnt_valid(vld_r),
    .gnt_ready(rdy_r), .gnt_idx(idx_r), .gnt_onehot(oh_r));

  rr_priority_arbiter #(.NUM_REQ(5), .MODE(ARB_RR)) u_n5 (
    .clk(clk), .rst_n(rst_n), .req(req_5), .gnt_valid(vld_5),
    .gnt_ready(rdy_5), .gnt_idx(idx_5), .gnt_onehot(oh_5));

  rr_priority_arbiter #(.NUM_REQ(1), .MODE(ARB_RR)) u_one (
    .clk(clk), .rst_n(rst_n), .req(req_1), .gnt_valid(vld_1),
    .gnt_ready(rdy_1), .gnt_idx(idx_1), .gnt_onehot(oh_1));

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic v_obs, input int i_obs,
                         input logic [63:0] oh_obs, input logic v_exp, input int i_exp);
    logic [63:0] oh_exp;
    oh_exp = v_exp ? (64'd1 << i_exp) : 64'd0;
    check({tag, "_valid"}, 64'(v_obs), 64'(v_exp));
    if (v_exp) check({tag, "_idx"}, 64'(i_obs), 64'(i_exp));
    check({tag, "_onehot"}, oh_obs, oh_exp);
  endtask

  function automatic int pick8(input logic [7:0] v, input int start, input logic fixed);
    int c;
    if (fixed) begin
      for (int i = 7; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int k = 0; k < 8; k++) begin
        c = (start + k) % 8;
        if (v[c[2:0]]) return c;
      end
    end
    return -1;
  endfunction

  task automatic model_step(input int j, input logic [7:0] r, input logic rdy, input logic fixed);
    int p;
    if (!m_valid[j]) begin
      p = pick8(r, (m_ptr[j] + 1) % 8, fixed);
      if (p >= 0) begin
        m_valid[j] = 1'b1;
        m_idx[j]   = p;
      end
    end else if (rdy) begin
      if (!fixed) m_ptr[j] = m_idx[j];
      p = pick8(r & ~(8'd1 << m_idx[j]), (m_ptr[j] + 1) % 8, fixed);
      if (p >= 0) m_idx[j] = p;
      else        m_valid[j] = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_f = 8'hFF; req_r = 8'hFF; rdy_f = 1'b0; rdy_r = 1'b0;
    req_5 = '0; rdy_5 = 1'b0; req_1 = 1'b0; rdy_1 = 1'b0;

    // Reset held with all requests asserted
    repeat (3) tick();
    chk_gnt("rst_rr", vld_r, int'(idx_r), 64'(oh_r), 1'b0, 0);
    check("rst_rr_idx", 64'(idx_r), 64'd0);
    chk_gnt("rst_fix", vld_f, int'(idx_f), 64'(oh_f), 1'b0, 0);
    check("rst_fix_idx", 64'(idx_f), 64'd0);
    rst_n = 1'b1;
    tick();
    chk_gnt("rel_rr", vld_r, int'(idx_r), 64'(oh_r), 1'b1, 0);
    chk_gnt("rel_fix", vld_f, int'(idx_f), 64'(oh_f), 1'b1, 7);

    // Round-robin fairness, one grant per cycle
    rdy_r = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk_gnt("rr_fair", vld_r, int'(idx_r), 64'(oh_r), 1'b1, k % 8);
    end
    chk_gnt("fix_held", vld_f, int'(idx_f), 64'(oh_f), 1'b1, 7);
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk_gnt("rr_fair2", vld_r, int'(idx_r), 64'(oh_r), 1'b1, k);
    end

    // Round-robin wrap after the handshake on 6
    req_r = 8'b0100_0001;
    tick(); chk_gnt("rr_wrap0", vld_r, int'(idx_r), 64'(oh_r), 1'b1, 0);
    tick(); chk_gnt("rr_wrap1", vld_r, int'(idx_r), 64'(oh_r), 1'b1, 6);
    tick(); chk_gnt("rr_wrap2", vld_r, int'(idx_r), 64'(oh_r), 1'b1, 0);
    rdy_r = 1'b0;

    // Fixed priority with masking
    req_f = 8'b0010_0110; rdy_f = 1'b1;
    tick(); chk_gnt("fix_a", vld_f, int'(idx_f), 64'(oh_f), 1'b1, 5);
    tick(); chk_gnt("fix_b", vld_f, int'(idx_f), 64'(oh_f), 1'b1, 2);
    tick(); chk_gnt("fix_c", vld_f, int'(idx_f), 64'(oh_f), 1'b1, 5);
    req_f = 8'b0000_0100;
    tick(); chk_gnt("fix_alt0", vld_f, int'(idx_f), 64'(oh_f), 1'b1, 2);
    tick(); chk_gnt("fix_alt1", vld_f, int'(idx_f), 64'(oh_f), 1'b0, 0);
    tick(); chk_gnt("fix_alt2", vld_f, int'(idx_f), 64'(oh_f), 1'b1, 2);
    tick(); chk_gnt("fix_alt3", vld_f, int'(idx_f), 64'(oh_f), 1'b0, 0);

    // Backpressure: grant frozen while req changes
    req_f = 8'b0010_0110; rdy_f = 1'b0;
    tick(); chk_gnt("bp_load", vld_f, int'(idx_f), 64'(oh_f), 1'b1, 5);
    req_f = 8'h01;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_gnt("bp_hold", vld_f, int'(idx_f), 64'(oh_f), 1'b1, 5);
    end
    rdy_f = 1'b1;
    tick(); chk_gnt("bp_next", vld_f, int'(idx_f), 64'(oh_f), 1'b1, 0);
    tick(); chk_gnt("bp_idle", vld_f, int'(idx_f), 64'(oh_f), 1'b0, 0);
    rdy_f = 1'b0;

    // Reset in the middle of a held grant
    req_r = 8'h08; rdy_r = 1'b1;
    tick(); chk_gnt("mid_load", vld_r, int'(idx_r), 64'(oh_r), 1'b1, 3);
    rdy_r = 1'b0;
    tick(); chk_gnt("mid_hold", vld_r, int'(idx_r), 64'(oh_r), 1'b1, 3);
    rst_n = 1'b0;
    #1;
    chk_gnt("mid_rst", vld_r, int'(idx_r), 64'(oh_r), 1'b0, 0);
    check("mid_rst_idx", 64'(idx_r), 64'd0);
    req_r = 8'h81; req_f = 8'h80;
    #1 rst_n = 1'b1;
    tick();
    chk_gnt("post_rst_rr", vld_r, int'(idx_r), 64'(oh_r), 1'b1, 0);
    chk_gnt("post_rst_fix", vld_f, int'(idx_f), 64'(oh_f), 1'b1, 7);

    // Non-power-of-2 wrap, NUM_REQ=5
    req_5 = 5'b10001; rdy_5 = 1'b1;
    tick(); chk_gnt("n5_a", vld_5, int'(idx_5), 64'(oh_5), 1'b1, 0);
    tick(); chk_gnt("n5_b", vld_5, int'(idx_5), 64'(oh_5), 1'b1, 4);
    tick(); chk_gnt("n5_c", vld_5, int'(idx_5), 64'(oh_5), 1'b1, 0);
    req_5 = 5'b00100;
    tick(); chk_gnt("n5_d", vld_5, int'(idx_5), 64'(oh_5), 1'b1, 2);
    tick(); chk_gnt("n5_e", vld_5, int'(idx_5), 64'(oh_5), 1'b0, 0);

    // Single requester alternates
    req_1 = 1'b1; rdy_1 = 1'b1;
    tick(); chk_gnt("one_a", vld_1, int'(idx_1), 64'(oh_1), 1'b1, 0);
    tick(); chk_gnt("one_b", vld_1, int'(idx_1), 64'(oh_1), 1'b0, 0);
    tick(); chk_gnt("one_c", vld_1, int'(idx_1), 64'(oh_1), 1'b1, 0);

    // Random req/ready against a reference model
    rst_n = 1'b0; rdy_f = 1'b0; rdy_r = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 2; j++) begin
      m_valid[j] = 1'b0; m_idx[j] = 0; m_ptr[j] = 7;
    end
    for (int n = 0; n < 300; n++) begin
      req_f = (n % 3 == 0) ? 8'($urandom) & 8'($urandom) : 8'($urandom);
      req_r = (n % 4 == 0) ? 8'($urandom) & 8'($urandom) : 8'($urandom);
      rdy_f = ($urandom_range(0, 9) < 7);
      rdy_r = ($urandom_range(0, 9) < 7);
      model_step(0, req_f, rdy_f, 1'b1);
      model_step(1, req_r, rdy_r, 1'b0);
      tick();
      chk_gnt("rnd_fix", vld_f, int'(idx_f), 64'(oh_f), m_valid[0], m_idx[0]);
      chk_gnt("rnd_rr", vld_r, int'(idx_r), 64'(oh_r), m_valid[1], m_idx[1]);
      check("rnd_oh0_fix", 64'($onehot0(oh_f)), 64'd1);
      check("rnd_oh0_rr", 64'($onehot0(oh_r)), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Registered N-way arbiter that generalises the combinational priority encoder.
- Selectable fixed-priority or round-robin mode.
- Grant is presented on a valid/ready handshake and held stable under backpressure.
- Sits between N request sources and one shared resource; a consumer accepts each grant via gnt_ready.

Parameters:
- NUM_REQ, 8, number of requesters; legal range 1..64.
- MODE, ARB_RR, arbitration mode (arb_pkg::arb_mode_e): ARB_FIXED or ARB_RR.
- IDX_W, derived localparam, max(1, $clog2(NUM_REQ)); width of the grant index.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  level request vector; bit i is requester i.
- gnt_valid  out  1  grant is presented.
- gnt_ready  in  1  consumer accepts the grant; handshake = gnt_valid & gnt_ready.
- gnt_idx  out  IDX_W  index of the granted requester.
- gnt_onehot  out  NUM_REQ  one-hot form of gnt_idx; all-zero when gnt_valid=0.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - gnt_valid=0, gnt_idx=0, gnt_onehot=0.
  - state=IDLE, rr pointer ptr=NUM_REQ-1, so the first RR search starts at index 0.
- All outputs are registered; there is no combinational path from req or gnt_ready to any output.
- States: IDLE, GRANT.
- IDLE:
  - If |req, arbitrate on req, register the winner, go to GRANT. gnt_valid rises the cycle after req is seen (1-cycle latency).
  - Otherwise stay in IDLE.
- GRANT with gnt_ready=0:
  - gnt_idx and gnt_onehot are held unchanged.
  - Changes on req, including the granted bit dropping, are ignored until the handshake.
- GRANT with gnt_ready=1 (handshake cycle):
  - ARB_RR: ptr <= gnt_idx.
  - Arbitrate on masked = req & ~gnt_onehot, using the updated priority.
  - If |masked, load the new grant and stay in GRANT. This gives back-to-back grants at one per cycle.
  - Otherwise clear gnt_valid and go to IDLE.
- Masking consequence: a requester cannot win twice in consecutive cycles. With a single persistent requester, gnt_valid alternates 1,0,1,0.
- Arbitration rules:
  - ARB_FIXED: highest set index wins.
  - ARB_RR: search ascending from (ptr+1) mod NUM_REQ, wrapping; first set bit wins.
  - ptr updates only on a handshake, never on the initial grant out of IDLE.
- Wrap-around:
  - With ptr=NUM_REQ-1, the search starts at 0.
  - Index arithmetic is mod NUM_REQ and must be correct for non-power-of-2 NUM_REQ; no out-of-range index may be produced.
- NUM_REQ=1:
  - IDX_W=1 and gnt_idx is always 0.
  - Both modes behave identically.
- Reset mid-grant: gnt_valid drops immediately (asynchronous). A grant pending at reset is lost and must not reappear after reset release.
- Invariants:
  - gnt_onehot == (gnt_valid ? 1<<gnt_idx : 0).
  - $onehot0(gnt_onehot).
  - When gnt_valid rises, the granted bit was set in the arbitrated vector.

Decomposition:
- arb_pkg:
  - typedef enum arb_mode_e {ARB_FIXED, ARB_RR}.
  - typedef enum arb_state_e {IDLE, GRANT}.
  - function clog2_min1 for IDX_W.
- Sub-module rr_pick, combinational, parameter NUM_REQ:
  - Inputs: vec, start_idx, fixed_mode.
  - Outputs: found, idx, onehot.
  - Implements rotated first-set search, using a double-width vector or rotate-then-encode.
  - Instantiated once in rr_priority_arbiter for both IDLE and handshake arbitration, with the input selected by state.

Test Plan (NUM_REQ=8):
1. Reset: hold rst_n=0 with req=8'hFF → gnt_valid=0, gnt_idx=0, gnt_onehot=0. Release → grant idx 0 one cycle later (RR).
2. ARB_FIXED, req=8'b0010_0110, ready=1 → grant sequence 5, 2, 5 (bit masking alternates). With req=8'b0000_0100 alone → gnt_valid pattern 1,0,1.
3. Backpressure: grant idx 5 held with ready=0 for 5 cycles while req changes to 8'h01 → gnt_idx=5 and gnt_onehot=8'h20 stable throughout. Raise ready → next grant idx 0.
4. ARB_RR fairness: req=8'hFF constant, ready=1 → gnt_idx 0,1,2,...,7,0,1 at one grant per cycle, gnt_valid continuously 1.
5. ARB_RR wrap: after handshake on idx 6, req=8'b0100_0001 → next grant 0, then 6, then 0.
6. Reset mid-grant: gnt_valid=1 at idx 3 with ready=0; pulse rst_n low between clock edges → gnt_valid=0 before the next edge. After release with req=8'h80 → grant idx 7, ptr restarts at 7.
7. Throughout all runs, assertions check the invariants against a golden model over random req and gnt_ready.
